dmem_sram_bridge: RTL

- Downstream of the dual-issue memory-control stage.
- Takes the single selected M-stage memory request (address, pre-aligned write data, byte enables, size) and drives it onto the SRAM-like data bus (req / addr_ok / data_ok).
- Stalls the pipeline while the transaction is outstanding.
- Returns the raw bus word as mem_rdataM2 to the M2-stage load-extension logic.
- Only one transaction is outstanding at a time.

---
 rtl/dmem_pkg.sv | 15 +
 rtl/dmem_sram_bridge.sv | 134 +++++++++++++
 2 files changed

// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared state encoding and access-size constants for dmem_sram_bridge
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2,
    HOLD = 2'd3
  } dmem_state_t;

  localparam logic [1:0] SIZE_B = 2'd0;
  localparam logic [1:0] SIZE_H = 2'd1;
  localparam logic [1:0] SIZE_W = 2'd2;

endpackage

// File: rtl/dmem_sram_bridge.sv
// rtl/dmem_sram_bridge.sv - M-stage request to SRAM-like data bus bridge (optional DMEM_RDATA_BYPASS_EN)
module dmem_sram_bridge
  import dmem_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                mem_en,
  input  logic [DATA_W/8-1:0] mem_wen,
  input  logic [ADDR_W-1:0]   mem_addr,
  input  logic [DATA_W-1:0]   mem_wdata,
  input  logic [1:0]          mem_size,
  input  logic                flush,
  input  logic                other_stall,
  output logic                mem_stall,
  output logic [DATA_W-1:0]   mem_rdataM2,
  output logic                data_req,
  output logic                data_wr,
  output logic [1:0]          data_size,
  output logic [ADDR_W-1:0]   data_addr,
  output logic [DATA_W/8-1:0] data_wstrb,
  output logic [DATA_W-1:0]   data_wdata,
  input  logic                data_addr_ok,
  input  logic                data_data_ok,
  input  logic [DATA_W-1:0]   data_rdata
);

  dmem_state_t       state;
  dmem_state_t       state_next;
  logic              cancel;
  logic [DATA_W-1:0] rdata_q;

  // a new request is taken only from IDLE and only for a live instruction
  logic accept;
  assign accept = (state == IDLE) && mem_en && !flush;

  // a flush arriving in the response cycle itself also discards the data
  logic cancel_now;
  assign cancel_now = cancel || flush;

  logic resp_done;
  assign resp_done = (state == DATA) && data_data_ok;

  logic load_update;
  assign load_update = resp_done && !data_wr && !cancel_now;

  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // next-state logic; a raised request is held until the bus accepts it
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (accept) begin
          state_next = ADDR;
        end
      end
      ADDR: begin
        if (data_addr_ok) begin
          state_next = DATA;
        end
      end
      DATA: begin
        if (data_data_ok) begin
          state_next = (other_stall && !cancel_now) ? HOLD : IDLE;
        end
      end
      HOLD: begin
        if (!other_stall) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // request fields are captured once at acceptance and stay stable on the bus
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_addr  <= '0;
      data_wdata <= '0;
      data_wstrb <= '0;
      data_size  <= SIZE_B;
      data_wr    <= 1'b0;
    end else if (accept) begin
      data_addr  <= mem_addr;
      data_wdata <= mem_wdata;
      data_wstrb <= mem_wen;
      data_size  <= mem_size;
      data_wr    <= |mem_wen;
    end
  end

  // cancel remembers a flush of the outstanding instruction until its response
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cancel <= 1'b0;
    end else if (resp_done || state == IDLE || state == HOLD) begin
      cancel <= 1'b0;
    end else if (flush) begin
      cancel <= 1'b1;
    end
  end

  // load data is captured on the response; stores and cancelled loads leave it alone
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata_q <= '0;
    end else if (load_update) begin
      rdata_q <= data_rdata;
    end
  end

  assign data_req = (state == ADDR);

`ifdef DMEM_RDATA_BYPASS_EN
  // the response cycle releases the pipeline and forwards the bus word directly
  assign mem_stall   = accept || (state == ADDR) || ((state == DATA) && !data_data_ok);
  assign mem_rdataM2 = load_update ? data_rdata : rdata_q;
`else
  assign mem_stall   = accept || (state == ADDR) || (state == DATA);
  assign mem_rdataM2 = rdata_q;
`endif

endmodule
